// File: rtl/pe_pass_controller.sv
// Pass sequencer for one convolution PE datapath.
// A job loads the IF window and the filter once. It then runs num filter passes
// over the same window and drains the MAC pipe after each pass.
// Every output is a flop. Each output's next value is decoded from the next state,
// so a pulse is high during exactly the cycle its state occupies.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; out_count holds the last job's result
// S_LOAD  | clear regs, kick IF and filter loads (1 cycle)
// S_ARM   | kick the read address generator (1 cycle)
// S_RUN   | pass in progress; count psums, ack stride reloads
// S_DRAIN | flush IF_reg/mult_reg for DRAIN_CYCLES; psums still counted
// S_NEXT  | advance filter index, rewind filter, reload IF (1 cycle)
// S_FIN   | done pulse (1 cycle)
module pe_pass_controller #(
  parameter int FILT_CNT_W   = 4,
  parameter int OUT_CNT_W    = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FILT_CNT_W-1:0] cfg_num_filt,
  input  logic                  cfg_psum_in,
  input  logic                  full_done,
  input  logic                  psum_done,
  input  logic                  stride_pos_ld,
  output logic                  IF_read_start,
  output logic                  filter_read_start,
  output logic                  start_rd_gen,
  output logic                  regs_clr,
  output logic                  IF_mux_sel,
  output logic                  filter_mux_sel,
  output logic                  reset_accumulation,
  output logic                  accumulate_input_psum,
  output logic                  usage_stride_pos_ld,
  output logic                  reset_Filter,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_CNT_W-1:0]  out_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_RUN, S_DRAIN, S_NEXT, S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [FILT_CNT_W-1:0] num_q, num_d;
  logic [FILT_CNT_W-1:0] filt_idx_q, filt_idx_d;
  logic                  psum_in_q, psum_in_d;
  logic [OUT_CNT_W-1:0]  out_count_q, out_count_d;
  logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic [FILT_CNT_W:0]   pass_next;

  logic if_read_start_q, if_read_start_d;
  logic filter_read_start_q, filter_read_start_d;
  logic start_rd_gen_q, start_rd_gen_d;
  logic regs_clr_q, regs_clr_d;
  logic if_mux_sel_q, if_mux_sel_d;
  logic filter_mux_sel_q, filter_mux_sel_d;
  logic reset_acc_q, reset_acc_d;
  logic acc_in_psum_q, acc_in_psum_d;
  logic usage_ld_q, usage_ld_d;
  logic reset_filter_q, reset_filter_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic in_pass;

  // Extended by one bit so the comparison against num cannot wrap at the top index.
  assign pass_next = {1'b0, filt_idx_q} + (FILT_CNT_W+1)'(1);

  // Next-state, job bookkeeping and counters.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    filt_idx_d  = filt_idx_q;
    psum_in_d   = psum_in_q;
    out_count_d = out_count_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d       = (cfg_num_filt == '0) ? FILT_CNT_W'(1) : cfg_num_filt;
          psum_in_d   = cfg_psum_in;
          filt_idx_d  = '0;
          out_count_d = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: state_d = S_ARM;
      S_ARM:  state_d = S_RUN;
      S_RUN: begin
        if (psum_done && !(&out_count_q)) out_count_d = out_count_q + OUT_CNT_W'(1);
        if (full_done) begin
          drain_cnt_d = DRAIN_LOAD;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (psum_done && !(&out_count_q)) out_count_d = out_count_q + OUT_CNT_W'(1);
        if (drain_cnt_q == '0) begin
          state_d = (pass_next < {1'b0, num_q}) ? S_NEXT : S_FIN;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
      S_NEXT: begin
        filt_idx_d = filt_idx_q + FILT_CNT_W'(1);
        state_d    = S_ARM;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output comes straight off a flop.
  always_comb begin
    in_pass             = (state_d == S_RUN) || (state_d == S_DRAIN);
    regs_clr_d          = (state_d == S_LOAD) || (state_d == S_NEXT);
    if_read_start_d     = (state_d == S_LOAD) || (state_d == S_NEXT);
    filter_read_start_d = (state_d == S_LOAD);
    start_rd_gen_d      = (state_d == S_ARM);
    reset_filter_d      = (state_d == S_NEXT);
    done_d              = (state_d == S_FIN);
    busy_d              = (state_d != S_IDLE);
    if_mux_sel_d        = in_pass;
    filter_mux_sel_d    = in_pass && (filt_idx_d != '0);
    reset_acc_d         = in_pass && (filt_idx_d != '0);
    acc_in_psum_d       = in_pass && psum_in_d && (filt_idx_d == '0);
    usage_ld_d          = (state_q == S_RUN) && stride_pos_ld;
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= S_IDLE;
      num_q               <= '0;
      filt_idx_q          <= '0;
      psum_in_q           <= 1'b0;
      out_count_q         <= '0;
      drain_cnt_q         <= '0;
      if_read_start_q     <= 1'b0;
      filter_read_start_q <= 1'b0;
      start_rd_gen_q      <= 1'b0;
      regs_clr_q          <= 1'b0;
      if_mux_sel_q        <= 1'b0;
      filter_mux_sel_q    <= 1'b0;
      reset_acc_q         <= 1'b0;
      acc_in_psum_q       <= 1'b0;
      usage_ld_q          <= 1'b0;
      reset_filter_q      <= 1'b0;
      busy_q              <= 1'b0;
      done_q              <= 1'b0;
    end else begin
      state_q             <= state_d;
      num_q               <= num_d;
      filt_idx_q          <= filt_idx_d;
      psum_in_q           <= psum_in_d;
      out_count_q         <= out_count_d;
      drain_cnt_q         <= drain_cnt_d;
      if_read_start_q     <= if_read_start_d;
      filter_read_start_q <= filter_read_start_d;
      start_rd_gen_q      <= start_rd_gen_d;
      regs_clr_q          <= regs_clr_d;
      if_mux_sel_q        <= if_mux_sel_d;
      filter_mux_sel_q    <= filter_mux_sel_d;
      reset_acc_q         <= reset_acc_d;
      acc_in_psum_q       <= acc_in_psum_d;
      usage_ld_q          <= usage_ld_d;
      reset_filter_q      <= reset_filter_d;
      busy_q              <= busy_d;
      done_q              <= done_d;
    end
  end

  assign IF_read_start         = if_read_start_q;
  assign filter_read_start     = filter_read_start_q;
  assign start_rd_gen          = start_rd_gen_q;
  assign regs_clr              = regs_clr_q;
  assign IF_mux_sel            = if_mux_sel_q;
  assign filter_mux_sel        = filter_mux_sel_q;
  assign reset_accumulation    = reset_acc_q;
  assign accumulate_input_psum = acc_in_psum_q;
  assign usage_stride_pos_ld   = usage_ld_q;
  assign reset_Filter          = reset_filter_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign out_count             = out_count_q;

endmodule

// File: tb/tb_pe_pass_controller.sv
// Bench for pe_pass_controller: the driver issues jobs and pushes expected
// per-pass and per-job results; a negedge monitor pops and compares them.
module tb_pe_pass_controller;

  localparam int FW   = 4;
  localparam int OW   = 6;
  localparam int D    = 2;
  localparam int MAXC = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [FW-1:0] cfg_num_filt = '0;
  logic          cfg_psum_in = 1'b0;
  logic          full_done = 1'b0;
  logic          psum_done = 1'b0;
  logic          stride_pos_ld = 1'b0;
  logic IF_read_start, filter_read_start, start_rd_gen, regs_clr, IF_mux_sel;
  logic filter_mux_sel, reset_accumulation, accumulate_input_psum;
  logic usage_stride_pos_ld, reset_Filter, busy, done;
  logic [OW-1:0] out_count;

  pe_pass_controller #(.FILT_CNT_W(FW), .OUT_CNT_W(OW), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_filt(cfg_num_filt),
    .cfg_psum_in(cfg_psum_in), .full_done(full_done), .psum_done(psum_done),
    .stride_pos_ld(stride_pos_ld), .IF_read_start(IF_read_start),
    .filter_read_start(filter_read_start), .start_rd_gen(start_rd_gen),
    .regs_clr(regs_clr), .IF_mux_sel(IF_mux_sel), .filter_mux_sel(filter_mux_sel),
    .reset_accumulation(reset_accumulation), .accumulate_input_psum(accumulate_input_psum),
    .usage_stride_pos_ld(usage_stride_pos_ld), .reset_Filter(reset_Filter),
    .busy(busy), .done(done), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct { int fm; int acc; } pass_t;
  typedef struct { int cnt; int passes; } job_t;

  pass_t pass_q[$];
  job_t  job_q[$];
  int    ack_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int last_fd_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] all_outs();
    return {IF_read_start, filter_read_start, start_rd_gen, regs_clr, IF_mux_sel,
            filter_mux_sel, reset_accumulation, accumulate_input_psum,
            usage_stride_pos_ld, reset_Filter, busy, done, out_count};
  endfunction

  // Monitor: pops expected records whenever the DUT presents a pulse.
  int    last_ifrd = -100;
  int    n_frs = 0, n_rdg = 0, n_rf = 0;
  bit    pass_pending = 1'b0;
  pass_t cur_pass;
  always @(negedge clk) begin
    if (!rst) begin
      n_frs = 0; n_rdg = 0; n_rf = 0; pass_pending = 1'b0;
    end else begin
      if (IF_read_start) begin
        last_ifrd = cyc;
        chk("regs_clr_with_if_read", regs_clr, 1);
      end
      if (filter_read_start) n_frs++;
      if (reset_Filter) n_rf++;
      if (pass_pending) begin
        pass_pending = 1'b0;
        chk("run_if_mux_sel", IF_mux_sel, 1);
        chk("run_filter_mux_sel", filter_mux_sel, cur_pass.fm);
        chk("run_reset_accumulation", reset_accumulation, cur_pass.fm);
        chk("run_accumulate_input_psum", accumulate_input_psum, cur_pass.acc);
      end
      if (start_rd_gen) begin
        n_rdg++;
        chk("arm_one_after_load", cyc - last_ifrd, 1);
        if (pass_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_start_rd_gen: got pulse, expected none (cycle %0d)", cyc);
        end else begin
          cur_pass = pass_q.pop_front();
          pass_pending = 1'b1;
        end
      end
      if (usage_stride_pos_ld) begin
        if (ack_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_stride_ack: got pulse, expected none (cycle %0d)", cyc);
        end else begin
          chk("stride_ack_cycle", cyc, ack_q.pop_front());
        end
      end
      if (done) begin
        if (job_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got pulse, expected none (cycle %0d)", cyc);
        end else begin
          job_t j;
          j = job_q.pop_front();
          chk("done_out_count", out_count, j.cnt);
          // drain cycles plus the FIN entry after the cycle full_done was seen
          chk("done_latency", cyc - last_fd_cyc, D + 1);
          chk("job_filter_read_starts", n_frs, 1);
          chk("job_start_rd_gen", n_rdg, j.passes);
          chk("job_reset_filter", n_rf, j.passes - 1);
        end
        n_frs = 0; n_rdg = 0; n_rf = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rd_gen(output bit ok);
    int k = 0;
    while (!start_rd_gen && k < 30) begin tick(); k++; end
    ok = start_rd_gen;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL wait_start_rd_gen: got timeout, expected pulse (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin tick(); k++; end
    chk("returns_idle", busy, 0);
  endtask

  // One job: plan psums per pass, push expectations, then drive the datapath flags.
  task automatic run_job(input int num_cfg, input bit psum_in, input int fixed_np,
                         input bit force_sc, input bit rnd);
    int n, total;
    int np[16];
    bit sc[16], dp[16];
    bit ok;
    pass_t pr;
    job_t jr;
    n = (num_cfg == 0) ? 1 : num_cfg;
    total = 0;
    for (int p = 0; p < n; p++) begin
      np[p] = (fixed_np >= 0) ? fixed_np : int'($urandom_range(0, 5));
      sc[p] = force_sc | (rnd & 1'($urandom_range(0, 1)));
      dp[p] = rnd & 1'($urandom_range(0, 1));
      total += np[p] + int'(sc[p]) + int'(dp[p]);
      pr.fm  = (p != 0) ? 1 : 0;
      pr.acc = (psum_in && p == 0) ? 1 : 0;
      pass_q.push_back(pr);
    end
    jr.cnt = (total > MAXC) ? MAXC : total;
    jr.passes = n;
    job_q.push_back(jr);

    start = 1'b1; cfg_num_filt = FW'(num_cfg); cfg_psum_in = psum_in;
    tick();
    start = 1'b0; cfg_num_filt = FW'($urandom); cfg_psum_in = 1'($urandom);
    for (int p = 0; p < n; p++) begin
      wait_rd_gen(ok);
      if (!ok) return;
      tick();
      for (int j = 0; j < np[p]; j++) begin
        psum_done = 1'b1;
        if (rnd && $urandom_range(0, 3) == 0) begin
          stride_pos_ld = 1'b1;
          ack_q.push_back(cyc + 1);
        end
        if (rnd && j == 0) start = 1'b1;
        tick();
        psum_done = 1'b0; stride_pos_ld = 1'b0; start = 1'b0;
        if (rnd && $urandom_range(0, 2) == 0) tick();
      end
      full_done = 1'b1; psum_done = sc[p]; last_fd_cyc = cyc;
      tick();
      full_done = 1'b0; psum_done = dp[p];
      tick();
      psum_done = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    bit ok;
    #1 rst = 1'b0;
    #2 chk("reset_outputs_async", all_outs(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("reset_state_outputs", all_outs(), 0);

    // single pass with three psums
    run_job(1, 1'b0, 3, 1'b0, 1'b0);
    chk("out_count_holds_in_idle", out_count, 3);
    // three passes
    run_job(3, 1'b0, -1, 1'b0, 1'b0);
    // external psum on pass 0 only; zero passes behaves as one
    run_job(2, 1'b1, 2, 1'b0, 1'b0);
    run_job(0, 1'b1, 1, 1'b0, 1'b0);
    // psum_done together with full_done
    run_job(2, 1'b0, 1, 1'b1, 1'b0);
    // saturation: 2^OW + 1 psums
    run_job(1, 1'b0, MAXC + 2, 1'b0, 1'b0);
    // start while busy, stride acks, drain psums, random shapes
    for (int r = 0; r < 8; r++)
      run_job(int'($urandom_range(0, 4)), 1'($urandom), -1, 1'b0, 1'b1);

    // abort mid-RUN: outputs drop immediately, no done follows
    pr_push_abort();
    start = 1'b1; cfg_num_filt = FW'(2); cfg_psum_in = 1'b0;
    tick();
    start = 1'b0;
    wait_rd_gen(ok);
    tick();
    psum_done = 1'b1;
    tick();
    psum_done = 1'b0;
    chk("abort_in_run", IF_mux_sel, 1);
    #2 rst = 1'b0;
    #1 chk("abort_outputs_async", all_outs(), 0);
    pass_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (6) tick();
    chk("abort_idle_after_release", busy, 0);
    chk("abort_out_count_cleared", out_count, 0);

    // normal job after the abort
    run_job(2, 1'b1, 2, 1'b0, 1'b0);

    repeat (5) tick();
    chk("pass_queue_drained", pass_q.size(), 0);
    chk("job_queue_drained", job_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // The aborted job still shows its first pass, so the monitor needs that record.
  task automatic pr_push_abort();
    pass_t pr;
    pr.fm = 0; pr.acc = 0;
    pass_q.push_back(pr);
  endtask

  initial begin
    #300000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
